sr_fetch_server: RTL
====================

Name: sr_fetch_server

Overview:
- Instruction-supply end of the dual-slot fetch interface: prefetches a sequential word stream from a synchronous instruction ROM and presents two consecutive instructions (cmd_1 at addr_1, cmd_2 at addr_1+1) with per-slot valids to the core-side arbiter.
- The consumer reports how many slots it took each cycle (0/1/2) and can redirect the stream on a taken branch.
- Sits between the instruction ROM and sr_cpu's arbiter, replacing the hardwired always-valid imData/imData2 pair.

Parameters:
- DEPTH, 4, prefetch buffer entries; power of two, >= 2
- MEM_LAT, 1, ROM read latency in cycles, 1..3
- RESET_ADDR, 0, word address fetched first after reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_1  out  32  instruction at addr_1; 32'h00000013 (NOP) when valid_1=0
- cmd_2  out  32  instruction at addr_1+1; NOP when valid_2=0
- valid_1  out  1  cmd_1 holds fetched data
- valid_2  out  1  cmd_2 holds fetched data; never high while valid_1 low
- addr_1  out  32  word address of cmd_1
- consumed  in  2  slots taken this cycle: 0, 1 or 2; 3 is illegal
- redirect  in  1  discard stream, restart at redirect_addr
- redirect_addr  in  32  new word address
- mem_rd  out  1  ROM read strobe
- mem_addr  out  32  ROM word address
- mem_rdata  in  32  ROM data, valid MEM_LAT cycles after mem_rd
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (clk edge with reset=1): buffer empty, in-flight pipeline cleared, fetch_ptr=addr_1=RESET_ADDR, err=0. While reset=1: mem_rd=0, valid_1=valid_2=0, cmd_1=cmd_2=NOP.
- Occupancy = buffer count + in-flight reads.
- mem_rd = !reset && !redirect && occupancy < DEPTH.
- mem_addr = fetch_ptr; fetch_ptr increments by 1 on each issued read, with 32-bit wrap.
- In-flight tracking: MEM_LAT-stage shift register of valid bits. A read issued in cycle n has its mem_rdata written to the buffer tail at the end of cycle n+MEM_LAT.
- Output visibility: written word appears on the outputs from cycle n+MEM_LAT+1.
- First valid_1 is high in cycle MEM_LAT+1 after reset release (cycle 0); valid_2 one cycle later.
- valid_1 = count>=1; valid_2 = count>=2.
- cmd_1 = buffer[head], cmd_2 = buffer[head+1], both combinational from registered state; no combinational path from consumed to the outputs.
- Consume: at the edge, head and addr_1 advance by consumed; count updates as count - consumed + write.
- Simultaneous write into a full-minus-consumed buffer is legal; occupancy gating guarantees no overflow.
- Illegal consume (consumed > count, or consumed==3): clamp to count, set err; err stays set until reset.
- Redirect in cycle n takes priority over consume and write:
  - buffer flushed, pipeline valid bits cleared, so late ROM data is dropped
  - fetch_ptr=addr_1=redirect_addr
  - no read issued in cycle n; fetching resumes in cycle n+1
  - first new valid_1 in cycle n+MEM_LAT+2
- Redirect while reset=1 is ignored.
- Head, tail and count wrap modulo DEPTH; count range 0..DEPTH.
- Back-to-back redirects: each restarts the stream; only the last target is ever delivered.
- Steady state, consuming 1 per cycle, MEM_LAT=1: sustained one word per cycle. Consuming 2 per cycle drains the buffer; this block supplies at most 1 word per cycle.

Decomposition:
- Shared package sr_fetch_pkg:
  - NOP constant 32'h00000013
  - consumed encodings CONS_NONE=0, CONS_ONE=1, CONS_TWO=2
  - DEPTH and MEM_LAT legality checks
- One sub-module: sr_fetch_fifo, a DEPTH-entry FIFO with single write, two read ports (head, head+1), variable pop 0..2, flush, and count output.
- sr_fetch_server keeps fetch_ptr, addr_1, the in-flight pipeline, err and the issue logic.

Test Plan:
- Reset release, ROM[i]=0x1000+i, MEM_LAT=1, consumed=0 -> valid_1 high in cycle 2 with cmd_1=0x1000, addr_1=0; valid_2 high in cycle 3 with cmd_2=0x1001; mem_rd drops after 4 issues; buffer holds 0x1000..0x1003.
- Steady consume=1 from cycle 2 -> cmd_1 = 0x1000, 0x1001, 0x1002… on consecutive cycles with no bubble; err=0.
- Full buffer, consumed=2 -> addr_1 advances by 2, cmd_1=0x1002; mem_rd reasserts the same cycle occupancy<4.
- redirect=1, redirect_addr=0x40 while two reads are in flight, MEM_LAT=3 -> stale data never appears; first valid_1 five cycles later with cmd_1=ROM[0x40], addr_1=0x40.
- consumed=2 with count=1 -> count becomes 0, err=1 and stays 1 until reset; consumed=3 also sets err.
- reset asserted mid-stream with a pending redirect -> next cycle all valids 0, cmd_1=NOP, mem_rd=0; restart at RESET_ADDR.

Source files
------------

// File: rtl/sr_fetch_pkg.sv
// Shared constants and parameter checks for the dual-slot instruction fetch server.
package sr_fetch_pkg;

    localparam logic [31:0] NOP = 32'h00000013;

    localparam logic [1:0] CONS_NONE = 2'd0;
    localparam logic [1:0] CONS_ONE  = 2'd1;
    localparam logic [1:0] CONS_TWO  = 2'd2;

    function automatic bit depth_ok(input int d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

    function automatic bit lat_ok(input int l);
        return (l >= 1) && (l <= 3);
    endfunction

endpackage

// File: rtl/sr_fetch_fifo.sv
// Prefetch buffer: one write port, two read ports (head, head+1), pop of 0..2 per cycle, flush.
module sr_fetch_fifo
    import sr_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_wr,
    input  logic [31:0]              i_wdata,
    input  logic [1:0]               i_pop,
    output logic [31:0]              o_rd0,
    output logic [31:0]              o_rd1,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_head1;

    // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH for free.
    assign w_head1 = r_head + AW'(1);
    assign o_rd0   = r_mem[r_head];
    assign o_rd1   = r_mem[w_head1];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_wr) begin
                r_tail <= r_tail + AW'(1);
            end
            r_head  <= r_head + AW'(i_pop);
            r_count <= r_count - (AW+1)'(i_pop) + (AW+1)'(i_wr);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !i_flush && i_wr) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        r_count <= (AW+1)'(DEPTH));

endmodule

// File: rtl/sr_fetch_server.sv
// Instruction supply for the dual-slot fetch: prefetches sequential ROM words and
// presents two consecutive instructions with per-slot valids; supports redirect.
module sr_fetch_server
    import sr_fetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int          MEM_LAT    = 1,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] cmd_1,
    output logic [31:0] cmd_2,
    output logic        valid_1,
    output logic        valid_2,
    output logic [31:0] addr_1,
    input  logic [1:0]  consumed,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (!depth_ok(DEPTH) || !lat_ok(MEM_LAT)) begin : g_bad_param
        $error("sr_fetch_server: DEPTH must be a power of two >= 2, MEM_LAT 1..3");
    end

    logic [31:0]      r_fetch_ptr;
    logic [31:0]      r_addr_1;
    logic [MEM_LAT:1] r_vld_pipe;
    logic             r_err;

    logic [CW-1:0]    w_count;
    logic [31:0]      w_rd0;
    logic [31:0]      w_rd1;
    logic [31:0]      w_occ;
    logic             w_wr;
    logic             w_illegal;
    logic [1:0]       w_req;
    logic [1:0]       w_pop;

    // In-flight reads count toward occupancy so the buffer can never overflow.
    always_comb begin
        w_occ = 32'(w_count);
        for (int k = 1; k <= MEM_LAT; k++) begin
            w_occ = w_occ + 32'(r_vld_pipe[k]);
        end
    end

    assign mem_rd   = !reset && !redirect && (w_occ < 32'(DEPTH));
    assign mem_addr = r_fetch_ptr;

    // A redirect drops the word arriving this cycle along with the rest of the stream.
    assign w_wr = r_vld_pipe[MEM_LAT] && !redirect;

    // Only two slots are ever presented, so an encoding of 3 is taken as a request for 2
    // before clamping to what is actually buffered.
    assign w_req     = (consumed == 2'd3) ? CONS_TWO : consumed;
    assign w_illegal = !redirect && ((consumed == 2'd3) || (32'(consumed) > 32'(w_count)));
    assign w_pop     = redirect ? CONS_NONE :
                       (32'(w_req) > 32'(w_count)) ? w_count[1:0] : w_req;

    sr_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (redirect),
        .i_wr    (w_wr),
        .i_wdata (mem_rdata),
        .i_pop   (w_pop),
        .o_rd0   (w_rd0),
        .o_rd1   (w_rd1),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_ptr <= RESET_ADDR;
            r_addr_1    <= RESET_ADDR;
            r_vld_pipe  <= '0;
            r_err       <= 1'b0;
        end else if (redirect) begin
            r_fetch_ptr <= redirect_addr;
            r_addr_1    <= redirect_addr;
            r_vld_pipe  <= '0;
        end else begin
            r_fetch_ptr   <= r_fetch_ptr + 32'(mem_rd);
            r_addr_1      <= r_addr_1 + 32'(w_pop);
            r_vld_pipe[1] <= mem_rd;
            for (int k = 2; k <= MEM_LAT; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
            end
            r_err         <= r_err | w_illegal;
        end
    end

    assign valid_1 = !reset && (w_count != '0);
    assign valid_2 = !reset && (w_count >= CW'(2));
    assign cmd_1   = valid_1 ? w_rd0 : NOP;
    assign cmd_2   = valid_2 ? w_rd1 : NOP;
    assign addr_1  = r_addr_1;
    assign err     = r_err;

endmodule
